// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : First-word-fall-through FIFO between fetch and decode, with
//            fetch stall, redirect flush and a sticky overflow flag.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_inst_valid,
    input  logic [31:0]              i_inst,
    input  logic [31:0]              i_fetch_pc,
    input  logic                     i_flush,
    output logic                     o_stall_fetch,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_inst,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_pc_plus_4,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int          c_AW  = $clog2(DEPTH);
    localparam int          c_CW  = c_AW + 1;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic [31:0]     r_inst [DEPTH];
    logic [31:0]     r_pc   [DEPTH];
    logic [c_AW-1:0] r_rd;
    logic [c_AW-1:0] r_wr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr_en;

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_push  = i_inst_valid && !i_flush;
    assign w_pop   = o_valid && i_ready && !i_flush;
    // A push into a full queue only lands when the head leaves the same cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= c_NOP;
                r_pc[i]   <= RESET_ADDR;
            end
        end else if (i_flush) begin
            r_count <= '0;
            r_rd    <= r_wr;
        end else begin
            if (w_wr_en) begin
                r_inst[r_wr] <= i_inst;
                r_pc[r_wr]   <= i_fetch_pc;
                r_wr         <= r_wr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_AW'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_wr_en) begin
                r_count <= r_count - c_CW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // One slot held back: fetch still delivers one pulse after stall rises.
    assign o_stall_fetch = (r_count >= c_CW'(DEPTH - 1));
    assign o_valid       = (r_count != '0);
    assign o_inst        = o_valid ? r_inst[r_rd] : c_NOP;
    assign o_pc          = r_pc[r_rd];
    assign o_pc_plus_4   = o_pc + 32'd4;
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed bench for fetch_queue with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic        stall_fetch;
    logic        valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] pc_plus_4;
    logic [$clog2(DEPTH):0] count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_inst_valid (inst_valid),
        .i_inst       (inst),
        .i_fetch_pc   (fetch_pc),
        .i_flush      (flush),
        .o_stall_fetch(stall_fetch),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_pc_plus_4  (pc_plus_4),
        .o_count      (count),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of {inst, pc} plus a sticky flag.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t m_q[$];
    logic   m_ovf = 1'b0;
    logic   m_live = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_live = 1'b1;
        end else if (flush) begin
            m_q.delete();
        end else begin
            automatic bit do_pop = (m_q.size() != 0) && ready;
            if (inst_valid && m_q.size() == DEPTH && !do_pop) begin
                m_ovf = 1'b1;
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (inst_valid) m_q.push_back('{inst: inst, pc: fetch_pc});
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            automatic bit m_valid = (m_q.size() != 0);
            check("valid", {31'd0, valid}, {31'd0, m_valid});
            check("count", 32'(count), 32'(m_q.size()));
            check("stall", {31'd0, stall_fetch}, {31'd0, (m_q.size() >= DEPTH - 1)});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("inst", o_inst, m_valid ? m_q[0].inst : NOP);
            if (m_valid) begin
                check("pc", o_pc, m_q[0].pc);
                check("pc_plus_4", pc_plus_4, m_q[0].pc + 32'd4);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] in, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic rn);
        inst_valid = v;
        inst       = in;
        fetch_pc   = pc;
        ready      = rdy;
        flush      = fl;
        rst_n      = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b1);
    endtask

    initial begin
        // 1. reset
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_inst", o_inst, NOP);
        check("rst_pc", o_pc, RESET_ADDR);
        check("rst_count", 32'(count), 32'd0);
        check("rst_stall", {31'd0, stall_fetch}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // 2. single push, one-cycle latency, popped next edge
        cyc(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0, 1'b1);
        check("t2_valid", {31'd0, valid}, 32'd1);
        check("t2_inst", o_inst, 32'h0050_0093);
        check("t2_pc", o_pc, 32'h0);
        check("t2_pc4", pc_plus_4, 32'h4);
        idle(1'b1);
        check("t2_empty", {31'd0, valid}, 32'd0);

        // 3. fill, stall, overflow, ordered drain
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1000 + 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b1);
        check("t3_count3", 32'(count), 32'd3);
        check("t3_stall", {31'd0, stall_fetch}, 32'd1);
        cyc(1'b1, 32'h1003, 32'hC, 1'b0, 1'b0, 1'b1);
        check("t3_count4", 32'(count), 32'd4);
        cyc(1'b1, 32'h1004, 32'h10, 1'b0, 1'b0, 1'b1);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_count_full", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t3_drain_pc", o_pc, 32'(4 * i));
            idle(1'b1);
        end
        check("t3_drained", {31'd0, valid}, 32'd0);

        // 4. full with simultaneous push/pop, then pointer wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h2000 + 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h2004, 32'h10, 1'b1, 1'b0, 1'b1);
        check("t4_count", 32'(count), 32'd4);
        check("t4_head", o_pc, 32'h4);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 2 * DEPTH; i++)
            cyc(1'b1, 32'h2005 + 32'(i), 32'h14 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
        check("t4_wrap_head", o_pc, 32'h24);
        check("t4_wrap_count", 32'(count), 32'd4);

        // 5. flush with same-cycle push
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h3000 + 32'(i), 32'h40 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h3003, 32'h4C, 1'b0, 1'b1, 1'b1);
        check("t5_count", 32'(count), 32'd0);
        check("t5_valid", {31'd0, valid}, 32'd0);
        check("t5_stall", {31'd0, stall_fetch}, 32'd0);
        check("t5_ovf", {31'd0, overflow}, 32'd0);
        cyc(1'b1, 32'h3004, 32'h100, 1'b0, 1'b0, 1'b1);
        check("t5_head", o_pc, 32'h100);
        idle(1'b1);

        // 6. pc+4 wrap and mid-operation reset
        cyc(1'b1, 32'h4000, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        check("t6_pc", o_pc, 32'hFFFF_FFFC);
        check("t6_pc4", pc_plus_4, 32'h0);
        cyc(1'b1, 32'h4001, 32'h0, 1'b0, 1'b0, 1'b1);
        check("t6_count2", 32'(count), 32'd2);
        cyc(1'b1, 32'h4002, 32'h8, 1'b1, 1'b0, 1'b0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_valid", {31'd0, valid}, 32'd0);
        check("t6_rst_pc", o_pc, RESET_ADDR);
        idle(1'b0);
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
